// File: rtl/comparator_search.sv
// Binary-search driver for an external magnitude comparator: presents trial
// operands on `guess` and narrows [lo, hi] from the gt/lt/eq flags until `a` is known.
module comparator_search #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         gt,
  input  logic                         lt,
  input  logic                         eq,
  output logic [WIDTH-1:0]             guess,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [WIDTH-1:0]             found,
  output logic [$clog2(WIDTH+2)-1:0]   probes
);

  localparam int PW = $clog2(WIDTH + 2);
  localparam logic [WIDTH:0]   MAX_W1   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ONE_W1   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [PW-1:0]    ONE_PW   = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   lo_r;
  logic [WIDTH:0]   hi_r;

  logic [WIDTH:0]   guess_ext_s;
  logic [WIDTH:0]   lo_nxt_s;
  logic [WIDTH:0]   hi_nxt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] guess_nxt_s;
  logic             flag_fault_s;
  logic             bounds_bad_s;
  logic             eq_only_s;
  logic             err_s;
  logic             resolve_s;

  assign guess_ext_s = {1'b0, guess};

  // Decode the comparator flags into updated bounds and flag-level faults.
  always_comb begin
    lo_nxt_s     = lo_r;
    hi_nxt_s     = hi_r;
    flag_fault_s = 1'b0;
    eq_only_s    = 1'b0;
    case ({gt, lt, eq})
      3'b100: begin
        lo_nxt_s     = guess_ext_s + ONE_W1;
        flag_fault_s = (guess == ALL_ONES);
      end
      3'b010: begin
        hi_nxt_s     = guess_ext_s - ONE_W1;
        flag_fault_s = (guess == ALL_ZERO);
      end
      3'b001: begin
        eq_only_s    = 1'b1;
      end
      default: begin
        flag_fault_s = 1'b1;
      end
    endcase
  end

  // An empty interval means the comparator contradicted an earlier answer.
  assign bounds_bad_s = (lo_nxt_s > hi_nxt_s);
  assign err_s        = flag_fault_s | bounds_bad_s;
  assign resolve_s    = eq_only_s | err_s;
  assign sum_s        = lo_nxt_s + hi_nxt_s;
  assign guess_nxt_s  = WIDTH'(sum_s >> 1);

  // Search FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      lo_r    <= '0;
      hi_r    <= '0;
      guess   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      found   <= '0;
      probes  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo_r    <= '0;
            hi_r    <= MAX_W1;
            guess   <= WIDTH'(MAX_W1 >> 1);
            probes  <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state_r <= PROBE;
          end else begin
            state_r <= IDLE;
          end
        end
        PROBE: begin
          probes <= probes + ONE_PW;
          if (resolve_s) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= FIN;
            if (err_s) begin
              err <= 1'b1;
            end else begin
              found <= guess;
            end
          end else begin
            lo_r    <= lo_nxt_s;
            hi_r    <= hi_nxt_s;
            guess   <= guess_nxt_s;
            state_r <= PROBE;
          end
        end
        FIN: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_search.sv
// Randomized self-checking bench for comparator_search at WIDTH=2 and WIDTH=4,
// checked against a plain-arithmetic binary-search reference.
module tb_comparator_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start2;
  logic [1:0] a2;
  logic       gt2, lt2, eq2;
  logic [1:0] guess2, found2, probes2;
  logic       busy2, done2, err2;

  logic       start4;
  logic [3:0] a4;
  logic       gt4, lt4, eq4;
  logic [3:0] guess4, found4;
  logic [2:0] probes4;
  logic       busy4, done4, err4;
  int         fault4;
  int         probe_idx4;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_q[$];

  comparator_search #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gt(gt2), .lt(lt2), .eq(eq2),
    .guess(guess2), .busy(busy2), .done(done2), .err(err2), .found(found2), .probes(probes2)
  );

  comparator_search #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .gt(gt4), .lt(lt4), .eq(eq4),
    .guess(guess4), .busy(busy4), .done(done4), .err(err4), .found(found4), .probes(probes4)
  );

  // Ideal comparators; the WIDTH=4 one can be forced into faulty answers.
  assign gt2 = (a2 > guess2);
  assign lt2 = (a2 < guess2);
  assign eq2 = (a2 == guess2);

  always_comb begin
    gt4 = (a4 > guess4);
    lt4 = (a4 < guess4);
    eq4 = (a4 == guess4);
    if (fault4 == 1 && busy4 && probe_idx4 == 2) begin
      gt4 = 1'b1; lt4 = 1'b1; eq4 = 1'b0;
    end
    if (fault4 == 2 && guess4 == 4'd0) begin
      gt4 = 1'b0; lt4 = 1'b1; eq4 = 1'b0;
    end
    if (fault4 == 3 && guess4 == 4'd15) begin
      gt4 = 1'b1; lt4 = 1'b0; eq4 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start4 && !busy4) probe_idx4 <= 1;
    else if (busy4)       probe_idx4 <= probe_idx4 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference search: fills exp_q with the guess sequence, returns the probe count.
  function automatic int ref_search(input int w, input int a);
    int lo, hi, g;
    exp_q.delete();
    lo = 0;
    hi = (1 << w) - 1;
    for (int n = 1; n <= w + 1; n++) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      if (g == a) return n;
      if (a > g) lo = g + 1;
      else       hi = g - 1;
    end
    return -1;
  endfunction

  task automatic run2(input int a);
    int k, n;
    int got[$];
    k = ref_search(2, a);
    @(posedge clk); #1;
    a2 = 2'(a);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("busy2_on", busy2, 1);
    n = 0;
    while (!done2 && n < 8) begin
      got.push_back(guess2);
      @(posedge clk); #1;
      n++;
    end
    chk("lat2", n, k);
    chk("nguess2", got.size(), k);
    for (int i = 0; i < got.size(); i++)
      chk("guess2", got[i], (i < exp_q.size()) ? exp_q[i] : -1);
    chk("done2", done2, 1);
    chk("found2", found2, a);
    chk("probes2", probes2, k);
    chk("err2", err2, 0);
    @(posedge clk); #1;
    chk("done2_pulse", done2, 0);
  endtask

  task automatic run4(input int a, input int mode, input bit poke);
    int k, n;
    int got[$];
    logic [3:0] prev_found;
    k = ref_search(4, a);
    if (mode == 1) k = 2;
    prev_found = found4;
    @(posedge clk); #1;
    a4 = 4'(a);
    fault4 = mode;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("busy4_on", busy4, 1);
    chk("err4_clr", err4, 0);
    n = 0;
    while (!done4 && n < 12) begin
      got.push_back(guess4);
      start4 = (poke && n == 1);
      @(posedge clk); #1;
      n++;
    end
    start4 = 1'b0;
    chk("lat4", n, k);
    chk("nguess4", got.size(), k);
    for (int i = 0; i < got.size(); i++)
      chk("guess4", got[i], (i < exp_q.size()) ? exp_q[i] : -1);
    chk("done4", done4, 1);
    chk("busy4_off", busy4, 0);
    chk("probes4", probes4, k);
    if (mode == 0) begin
      chk("found4", found4, a);
      chk("err4", err4, 0);
    end else begin
      chk("found4_keep", found4, prev_found);
      chk("err4_set", err4, 1);
    end
    @(posedge clk); #1;
    chk("done4_pulse", done4, 0);
    chk("err4_hold", err4, (mode != 0) ? 1 : 0);
    fault4 = 0;
  endtask

  initial begin
    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0;
    a2 = 2'd0; a4 = 4'd0; fault4 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_guess2", guess2, 0);
    chk("rst_found2", found2, 0);
    chk("rst_probes2", probes2, 0);
    chk("rst_flags2", {busy2, done2, err2}, 0);
    chk("rst_guess4", guess4, 0);
    chk("rst_found4", found4, 0);
    chk("rst_probes4", probes4, 0);
    chk("rst_flags4", {busy4, done4, err4}, 0);
    rst_n = 1'b1;

    run2(3);
    run2(1);
    run2(0);
    repeat (4) run2($urandom_range(3, 0));

    for (int a = 0; a < 16; a++) run4(a, 0, 1'b0);
    repeat (10) run4($urandom_range(15, 0), 0, 1'b0);

    run4(9, 0, 1'b1);
    run4(12, 1, 1'b0);
    run4(5, 0, 1'b0);
    run4(0, 2, 1'b0);
    run4(15, 3, 1'b0);
    run4($urandom_range(15, 0), 0, 1'b0);

    // Abort a search with reset during its second probe.
    @(posedge clk); #1;
    a4 = 4'd15;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_guess", guess4, 0);
    chk("abort_found", found4, 0);
    chk("abort_probes", probes4, 0);
    chk("abort_flags", {busy4, done4, err4}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_idle", {busy4, done4}, 0);
    end
    run4($urandom_range(15, 0), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
